// File: rtl/dff_bank_arbiter_pkg.sv
// rtl/dff_bank_arbiter_pkg.sv - shared state encoding and index-width helper for the bank arbiter
package dff_bank_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // A single requester still needs a 1-bit index field.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dff_bank_arbiter_rr_pick.sv
// rtl/dff_bank_arbiter_rr_pick.sv - combinational round-robin pick starting at ptr
module dff_bank_arbiter_rr_pick
  import dff_bank_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx,
  output logic             any
);

  // Walking ptr, ptr+1, ... with wrap is the rotate/encode/un-rotate in one pass.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      int j;
      j = (int'(ptr) + k) % N_REQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/dff_bank_arbiter.sv
// rtl/dff_bank_arbiter.sv - round-robin arbiter with lock feeding one shared register bank
module dff_bank_arbiter
  import dff_bank_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int IW    = idx_w(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       lock,
  input  logic [N_REQ*WIDTH-1:0] d_in,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       q,
  output logic                   q_valid,
  output logic [IW-1:0]          q_owner
);

  arb_state_e       r_state;
  logic [IW-1:0]    r_owner;
  logic [IW-1:0]    r_ptr;
  logic [WIDTH-1:0] r_q;
  logic             r_q_valid;
  logic [IW-1:0]    r_q_owner;

  logic [IW-1:0]    w_owner_next;
  logic [IW-1:0]    w_pick_ptr;
  logic [N_REQ-1:0] w_pick_gnt;
  logic [IW-1:0]    w_pick_idx;
  logic             w_pick_any;
  logic             w_hold;
  logic [N_REQ-1:0] w_gnt;
  logic [IW-1:0]    w_idx;
  logic             w_any;
  logic [IW-1:0]    w_idx_next;
  logic [WIDTH-1:0] w_data;

  assign w_owner_next = (r_owner == IW'(N_REQ-1)) ? '0 : r_owner + 1'b1;
  // An owner that drops req hands off in the same cycle, searching from just past itself.
  assign w_pick_ptr   = (r_state == ST_LOCKED) ? w_owner_next : r_ptr;
  assign w_hold       = (r_state == ST_LOCKED) && req[r_owner];

  dff_bank_arbiter_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req (req),
    .ptr (w_pick_ptr),
    .gnt (w_pick_gnt),
    .idx (w_pick_idx),
    .any (w_pick_any)
  );

  always_comb begin
    w_gnt = '0;
    w_idx = '0;
    w_any = 1'b0;
    if (rst) begin
      if (w_hold) begin
        w_gnt[r_owner] = 1'b1;
        w_idx          = r_owner;
        w_any          = 1'b1;
      end else begin
        w_gnt = w_pick_gnt;
        w_idx = w_pick_idx;
        w_any = w_pick_any;
      end
    end
  end

  assign w_idx_next = (w_idx == IW'(N_REQ-1)) ? '0 : w_idx + 1'b1;

  // AND-OR mux so undriven slices of unselected requesters never reach q.
  always_comb begin
    w_data = '0;
    for (int i = 0; i < N_REQ; i++)
      w_data = w_data | (d_in[i*WIDTH +: WIDTH] & {WIDTH{w_gnt[i]}});
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_owner   <= '0;
      r_ptr     <= '0;
      r_q       <= '0;
      r_q_valid <= 1'b0;
      r_q_owner <= '0;
    end else if (w_any) begin
      r_q       <= w_data;
      r_q_owner <= w_idx;
      r_q_valid <= 1'b1;
      if (lock[w_idx]) begin
        r_state <= ST_LOCKED;
        r_owner <= w_idx;
      end else begin
        r_state <= ST_IDLE;
        r_ptr   <= w_idx_next;
      end
    end else begin
      r_q_valid <= 1'b0;
      r_state   <= ST_IDLE;
    end
  end

  assign gnt     = w_gnt;
  assign q       = r_q;
  assign q_valid = r_q_valid;
  assign q_owner = r_q_owner;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// tb/tb_dff_bank_arbiter.sv - directed self-checking bench for dff_bank_arbiter
module tb_dff_bank_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [31:0] d_in;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic        q_valid;
  logic [1:0]  q_owner;

  int n_checks = 0;
  int n_fail   = 0;
  bit running  = 1'b1;

  dff_bank_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .lock    (lock),
    .d_in    (d_in),
    .gnt     (gnt),
    .q       (q),
    .q_valid (q_valid),
    .q_owner (q_owner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk)
    if (running) check("gnt_onehot0", {31'd0, $onehot0(gnt)}, 32'd1);

  task automatic step(input string tag, input logic [3:0] r, input logic [3:0] l,
                      input logic [3:0] exp_gnt);
    req  = r;
    lock = l;
    #1;
    check({tag, "_gnt"}, {28'd0, gnt}, {28'd0, exp_gnt});
    @(posedge clk);
    #1;
  endtask

  task automatic check_q(input string tag, input logic [7:0] eq, input logic ev,
                         input logic [1:0] eo);
    check({tag, "_q"},       {24'd0, q},       {24'd0, eq});
    check({tag, "_q_valid"}, {31'd0, q_valid}, {31'd0, ev});
    check({tag, "_q_owner"}, {30'd0, q_owner}, {30'd0, eo});
  endtask

  initial begin
    rst  = 1'b0;
    req  = 4'b1111;
    lock = 4'b0000;
    d_in = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

    for (int i = 0; i < 3; i++) step("reset", 4'b1111, 4'b0000, 4'b0000);
    check_q("reset", 8'h00, 1'b0, 2'd0);

    rst = 1'b1;
    step("rr0", 4'b1111, 4'b0000, 4'b0001); check_q("rr0", 8'hA0, 1'b1, 2'd0);
    step("rr1", 4'b1111, 4'b0000, 4'b0010); check_q("rr1", 8'hA1, 1'b1, 2'd1);
    step("rr2", 4'b1111, 4'b0000, 4'b0100); check_q("rr2", 8'hA2, 1'b1, 2'd2);
    step("rr3", 4'b1111, 4'b0000, 4'b1000); check_q("rr3", 8'hA3, 1'b1, 2'd3);
    step("rr4", 4'b1111, 4'b0000, 4'b0001); check_q("rr4", 8'hA0, 1'b1, 2'd0);

    // ptr=1: requester 2 wins and locks, starving requester 0
    step("lock_take", 4'b0101, 4'b0100, 4'b0100); check_q("lock_take", 8'hA2, 1'b1, 2'd2);
    for (int i = 0; i < 3; i++) step("lock_hold", 4'b0101, 4'b0100, 4'b0100);
    check_q("lock_hold", 8'hA2, 1'b1, 2'd2);
    step("lock_drop", 4'b0101, 4'b0000, 4'b0100);
    step("lock_after", 4'b0101, 4'b0000, 4'b0001); check_q("lock_after", 8'hA0, 1'b1, 2'd0);

    // ptr=1: lock on 1, then owner leaves and 2 is granted with no dead cycle
    step("leave_take", 4'b0010, 4'b0010, 4'b0010); check_q("leave_take", 8'hA1, 1'b1, 2'd1);
    step("leave_hand", 4'b1100, 4'b0000, 4'b0100); check_q("leave_hand", 8'hA2, 1'b1, 2'd2);
    step("leave_ptr3", 4'b1111, 4'b0000, 4'b1000); check_q("leave_ptr3", 8'hA3, 1'b1, 2'd3);

    // ptr=0
    d_in = {8'hA3, 8'hA2, 8'hA1, 8'h5A};
    step("gap_wr", 4'b0001, 4'b0000, 4'b0001); check_q("gap_wr", 8'h5A, 1'b1, 2'd0);
    step("gap0", 4'b0000, 4'b0000, 4'b0000); check_q("gap0", 8'h5A, 1'b0, 2'd0);
    step("gap1", 4'b0000, 4'b0000, 4'b0000); check_q("gap1", 8'h5A, 1'b0, 2'd0);
    step("gap_ptr", 4'b1111, 4'b0000, 4'b0010); check_q("gap_ptr", 8'hA1, 1'b1, 2'd1);

    // ptr=2: lock on 3, then reset mid-lock
    step("rl_take", 4'b1000, 4'b1000, 4'b1000); check_q("rl_take", 8'hA3, 1'b1, 2'd3);
    rst = 1'b0;
    step("rl_rst", 4'b1000, 4'b1000, 4'b0000); check_q("rl_rst", 8'h00, 1'b0, 2'd0);
    rst = 1'b1;
    step("rl_first", 4'b1001, 4'b0000, 4'b0001); check_q("rl_first", 8'h5A, 1'b1, 2'd0);

    // lock without a grant does nothing; ptr=1 here
    step("nolock", 4'b0100, 4'b1011, 4'b0100); check_q("nolock", 8'hA2, 1'b1, 2'd2);
    step("nolock2", 4'b0001, 4'b0000, 4'b0001);

    running = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
